data_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the CPU data port (MEM-stage load/store) and memory port 2 (read_m2/write_m2/address2/data2/inputReady2/ackOutput2).
- Hides multi-cycle memory latency on load hits.
- Fills whole lines word-by-word on load misses, because memory is word-addressed only.

---
 rtl/data_cache_pkg.sv | 24 ++
 rtl/data_cache_line_array.sv | 45 ++++
 rtl/data_cache.sv | 142 ++++++++++++++
 tb/tb_data_cache.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared widths, FSM encoding and address field helpers for the data cache
package data_cache_pkg;
  localparam int WORD_SIZE = 16;
  localparam int INDEX_BITS = 2;
  localparam int OFFSET_BITS = 2;
  localparam int TAG_BITS = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;
  localparam int MEM_STALL_COUNT = 2;
  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [TAG_BITS-1:0] tag_t;
  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [OFFSET_BITS-1:0] off_t;
  typedef enum logic [1:0] {IDLE, FILL, RESP, WRITE} state_e;
  function automatic tag_t tag_of(input word_t a);
    return a[WORD_SIZE-1 -: TAG_BITS];
  endfunction
  function automatic idx_t idx_of(input word_t a);
    return a[OFFSET_BITS +: INDEX_BITS];
  endfunction
  function automatic off_t off_of(input word_t a);
    return a[OFFSET_BITS-1:0];
  endfunction
endpackage

// File: rtl/data_cache_line_array.sv
// cache_line_array: valid/tag/data storage with a combinational read port, a word write port and a tag/valid write
module cache_line_array
  import data_cache_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  idx_t  rd_idx,
  input  off_t  rd_off,
  output logic  rd_valid,
  output tag_t  rd_tag,
  output word_t rd_word,
  input  logic  wr_en,
  input  idx_t  wr_idx,
  input  off_t  wr_off,
  input  word_t wr_word,
  input  logic  tv_en,
  input  idx_t  tv_idx,
  input  tag_t  tv_tag
);
  logic [LINES-1:0] valid_q, valid_d;
  tag_t tag_q [LINES];
  tag_t tag_d [LINES];
  word_t data_q [LINES][WORDS];
  word_t data_d [LINES][WORDS];
  assign rd_valid = valid_q[rd_idx];
  assign rd_tag = tag_q[rd_idx];
  assign rd_word = data_q[rd_idx][rd_off];
  // next-state of the storage: one word write and one tag/valid write per cycle
  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    data_d = data_q;
    if (wr_en) data_d[wr_idx][wr_off] = wr_word;
    if (tv_en) begin
      valid_d[tv_idx] = 1'b1;
      tag_d[tv_idx] = tv_tag;
    end
  end
  // only valid bits need clearing; tag/data are meaningless while invalid
  always_ff @(posedge clk) begin
    valid_q <= reset ? '0 : valid_d;
    tag_q <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-through no-write-allocate cache between the CPU data port and memory port 2
module data_cache
  import data_cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 read_m2,
  output logic                 write_m2,
  output logic [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2,
  input  logic                 inputReady2,
  input  logic                 ackOutput2,
  output logic [WORD_SIZE-1:0] hit_count,
  output logic [WORD_SIZE-1:0] miss_count
);
  state_e state_q, state_d;
  off_t cnt_q, cnt_d;
  logic first_q, first_d, d_ready_q, d_ready_d, read_q, read_d, write_q, write_d;
  word_t d_rdata_q, d_rdata_d, addr_q, addr_d, wdata_q, wdata_d, hit_q, hit_d, miss_q, miss_d;
  logic rd_valid, wr_en, tv_en, hit;
  tag_t rd_tag;
  word_t rd_word, wr_word;
  off_t wr_off;
  cache_line_array u_lines (
    .clk(clk), .reset(reset),
    .rd_idx(idx_of(d_address)), .rd_off(off_of(d_address)),
    .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_word(rd_word),
    .wr_en(wr_en), .wr_idx(idx_of(d_address)), .wr_off(wr_off), .wr_word(wr_word),
    .tv_en(tv_en), .tv_idx(idx_of(d_address)), .tv_tag(tag_of(d_address))
  );
  assign hit = rd_valid && rd_tag == tag_of(d_address);
  assign data2 = write_q ? wdata_q : 'z;
  assign d_rdata = d_rdata_q;
  assign d_ready = d_ready_q;
  assign read_m2 = read_q;
  assign write_m2 = write_q;
  assign address2 = addr_q;
  assign hit_count = hit_q;
  assign miss_count = miss_q;
  // request FSM: first_q masks stale memory handshakes during the first cycle of every memory request
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    first_d = first_q;
    d_ready_d = 1'b0;
    d_rdata_d = d_rdata_q;
    read_d = read_q;
    write_d = write_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    hit_d = hit_q;
    miss_d = miss_q;
    wr_en = 1'b0;
    wr_off = off_of(d_address);
    wr_word = d_wdata;
    tv_en = 1'b0;
    case (state_q)
      IDLE: if (!d_ready_q && d_read) begin
        if (hit) begin
          d_ready_d = 1'b1;
          d_rdata_d = rd_word;
          hit_d = hit_q + word_t'(1);
        end else begin
          miss_d = miss_q + word_t'(1);
          state_d = FILL;
          cnt_d = '0;
          first_d = 1'b1;
          read_d = 1'b1;
          addr_d = {tag_of(d_address), idx_of(d_address), off_t'(0)};
        end
      end else if (!d_ready_q && d_write) begin
        hit_d = hit ? hit_q + word_t'(1) : hit_q;
        miss_d = hit ? miss_q : miss_q + word_t'(1);
        wr_en = hit;
        state_d = WRITE;
        first_d = 1'b1;
        write_d = 1'b1;
        addr_d = d_address;
        wdata_d = d_wdata;
      end
      FILL: if (first_q) first_d = 1'b0;
      else if (inputReady2) begin
        wr_en = 1'b1;
        wr_off = cnt_q;
        wr_word = data2;
        if (cnt_q == '1) begin
          tv_en = 1'b1;
          read_d = 1'b0;
          state_d = RESP;
          d_ready_d = 1'b1;
          d_rdata_d = off_of(d_address) == cnt_q ? data2 : rd_word;
        end else begin
          cnt_d = cnt_q + off_t'(1);
          first_d = 1'b1;
          addr_d = {tag_of(d_address), idx_of(d_address), off_t'(cnt_q + off_t'(1))};
        end
      end
      RESP: state_d = IDLE;
      WRITE: if (first_q) first_d = 1'b0;
      else if (ackOutput2) begin
        write_d = 1'b0;
        d_ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // all control and output registers; reset abandons any in-flight memory request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      first_q <= 1'b0;
      d_ready_q <= 1'b0;
      d_rdata_q <= '0;
      read_q <= 1'b0;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      first_q <= first_d;
      d_ready_q <= d_ready_d;
      d_rdata_q <= d_rdata_d;
      read_q <= read_d;
      write_q <= write_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed checks of data_cache against a word-addressed memory model with stale handshakes
module tb_data_cache;
  import data_cache_pkg::*;
  logic clk = 0, reset = 1, d_read = 0, d_write = 0;
  logic [15:0] d_address = 0, d_wdata = 0;
  logic [15:0] d_rdata, address2, hit_count, miss_count;
  logic d_ready, read_m2, write_m2;
  logic inputReady2 = 0, ackOutput2 = 0;
  wire [15:0] data2;
  logic [15:0] mem [0:255];
  logic [15:0] rdat = 0, rd_addr = 0;
  logic rd_busy = 0;
  int rd_cnt = 0, wr_cnt = 0, both = 0, total = 0, bad = 0;
  logic [15:0] rq [$];
  logic [15:0] r;
  int lat, n;

  assign data2 = write_m2 ? 'z : rdat;
  always #5 clk = ~clk;

  data_cache dut (
    .clk(clk), .reset(reset), .d_read(d_read), .d_write(d_write),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .read_m2(read_m2), .write_m2(write_m2), .address2(address2), .data2(data2),
    .inputReady2(inputReady2), .ackOutput2(ackOutput2),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // memory model: a new read address drops inputReady2 one cycle late, so the old 1 is seen stale for one cycle
  always @(posedge clk) begin
    if (read_m2) begin
      if (!rd_busy || address2 != rd_addr) begin
        rq.push_back(address2);
        rd_busy <= 1;
        rd_addr <= address2;
        rd_cnt <= 1;
        inputReady2 <= 0;
      end else if (rd_cnt == MEM_STALL_COUNT) begin
        inputReady2 <= 1;
        rdat <= mem[address2[7:0]];
      end else rd_cnt <= rd_cnt + 1;
    end else begin
      rd_busy <= 0;
      inputReady2 <= 0;
    end
    if (write_m2) begin
      if (wr_cnt == MEM_STALL_COUNT) begin
        ackOutput2 <= 1;
        mem[address2[7:0]] <= data2;
      end else wr_cnt <= wr_cnt + 1;
    end else begin
      wr_cnt <= 0;
      ackOutput2 <= 0;
    end
  end

  always @(negedge clk) if (read_m2 && write_m2) both++;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag, output logic [15:0] rdata, output int cycles);
    cycles = 0;
    while (!d_ready && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk({tag, "_ready"}, 16'(d_ready), 16'd1);
    rdata = d_rdata;
    d_read = 0;
    d_write = 0;
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 16'(d_ready), 16'd0);
  endtask

  task automatic op(input string tag, input logic rd, input logic [15:0] a, input logic [15:0] wd,
                    output logic [15:0] rdata, output int cycles);
    d_read = rd;
    d_write = !rd;
    d_address = a;
    d_wdata = wd;
    wait_ready(tag, rdata, cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0400 + 16'(i);
    for (int i = 0; i < 4; i++) mem[16 + i] = 16'h00A0 + 16'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 16'(d_ready), 0);
    chk("rst_rdata", d_rdata, 0);
    chk("rst_read", 16'(read_m2), 0);
    chk("rst_write", 16'(write_m2), 0);
    chk("rst_addr", address2, 0);
    chk("rst_hit", hit_count, 0);
    chk("rst_miss", miss_count, 0);
    reset = 0;
    // load miss fills line 0 word by word
    rq.delete();
    op("t1", 1, 16'h0012, 0, r, lat);
    chk("t1_data", r, 16'h00A2);
    chk("t1_nreq", 16'(rq.size()), 4);
    for (int i = 0; i < 4; i++) chk("t1_req", rq[i], 16'h0010 + 16'(i));
    chk("t1_miss", miss_count, 1);
    chk("t1_hit", hit_count, 0);
    // load hit in one cycle, no memory traffic
    rq.delete();
    op("t2", 1, 16'h0011, 0, r, lat);
    chk("t2_data", r, 16'h00A1);
    chk("t2_lat", 16'(lat), 1);
    chk("t2_nreq", 16'(rq.size()), 0);
    chk("t2_hit", hit_count, 1);
    // store hit writes through and updates the line
    op("t3w", 0, 16'h0013, 16'hBEEF, r, lat);
    chk("t3_mem", mem[8'h13], 16'hBEEF);
    chk("t3_hit", hit_count, 2);
    op("t3r", 1, 16'h0013, 0, r, lat);
    chk("t3_data", r, 16'hBEEF);
    chk("t3_lat", 16'(lat), 1);
    chk("t3_hit2", hit_count, 3);
    // store miss does not allocate; later load of that address refills line 0
    op("t4w", 0, 16'h0040, 16'h1234, r, lat);
    chk("t4_mem", mem[8'h40], 16'h1234);
    chk("t4_miss", miss_count, 2);
    op("t4keep", 1, 16'h0012, 0, r, lat);
    chk("t4_keep_data", r, 16'h00A2);
    chk("t4_keep_lat", 16'(lat), 1);
    chk("t4_hit", hit_count, 4);
    rq.delete();
    op("t4r", 1, 16'h0040, 0, r, lat);
    chk("t4_data", r, 16'h1234);
    chk("t4_miss2", miss_count, 3);
    chk("t4_nreq", 16'(rq.size()), 4);
    chk("t4_req0", rq[0], 16'h0040);
    chk("t4_req3", rq[3], 16'h0043);
    op("t4tag", 1, 16'h0041, 0, r, lat);
    chk("t4_tag_data", r, 16'h0441);
    chk("t4_tag_lat", 16'(lat), 1);
    chk("t4_hit2", hit_count, 5);
    // back-to-back fills, each word request starts with a stale inputReady2
    op("t5a", 1, 16'h0025, 0, r, lat);
    chk("t5a_data", r, 16'h0425);
    op("t5b", 1, 16'h002A, 0, r, lat);
    chk("t5b_data", r, 16'h042A);
    chk("t5_miss", miss_count, 5);
    for (int a = 16'h24; a < 16'h2C; a++) begin
      op("t5h", 1, 16'(a), 0, r, lat);
      chk("t5_line", r, 16'h0400 + 16'(a));
      chk("t5_lat", 16'(lat), 1);
    end
    chk("t5_hit", hit_count, 13);
    // reset mid-fill abandons the request and forgets all lines
    d_read = 1;
    d_address = 16'h0031;
    n = 0;
    while (!(read_m2 && address2 == 16'h0032) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t6_reach", address2, 16'h0032);
    reset = 1;
    @(posedge clk);
    #1;
    chk("t6_read", 16'(read_m2), 0);
    chk("t6_write", 16'(write_m2), 0);
    chk("t6_ready", 16'(d_ready), 0);
    chk("t6_rdata", d_rdata, 0);
    chk("t6_addr", address2, 0);
    chk("t6_hit", hit_count, 0);
    chk("t6_miss", miss_count, 0);
    reset = 0;
    rq.delete();
    wait_ready("t6r", r, lat);
    chk("t6_data", r, 16'h0431);
    chk("t6_miss2", miss_count, 1);
    chk("t6_nreq", 16'(rq.size()), 4);
    for (int i = 0; i < 4; i++) chk("t6_req", rq[i], 16'h0030 + 16'(i));
    chk("excl", 16'(both), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
